// File: rtl/id_regfile_sb.sv
// id_regfile_sb: multi-port register file with a pending-write scoreboard and a
// registered issue stage. Optional macro RF_BYPASS_EN forwards same-cycle
// writeback data to the read ports and suppresses the hazard it resolves.
module id_regfile_sb #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned RD_PORTS  = 2
) (
   input  logic                          clk,
   input  logic                          rf_aresetn,
   input  logic                          clr,
   input  logic                          stall,
   input  logic                          i_valid,
   input  logic [RD_PORTS*REG_IDX_W-1:0] i_rd_idx,
   input  logic                          i_dest_en,
   input  logic [REG_IDX_W-1:0]          i_dest_reg,
   input  logic                          i_wb_dest_en,
   input  logic [REG_IDX_W-1:0]          i_wb_dest_reg,
   input  logic [WORD_W-1:0]             i_wb_dest_data,
   output logic [RD_PORTS*WORD_W-1:0]    o_rd_data,
   output logic                          o_valid,
   output logic                          o_hazard
);
   localparam int unsigned REG_CNT = 2 ** REG_IDX_W;

   logic [WORD_W-1:0]          mem [REG_CNT];
   logic [REG_CNT-1:0]         pending;
   logic [REG_CNT-1:0]         pending_nxt;
   logic [RD_PORTS-1:0]        port_haz;
   logic [RD_PORTS*WORD_W-1:0] rd_val;
   logic                       wb_act;
   logic                       issue;

   assign wb_act = i_wb_dest_en && (i_wb_dest_reg != '0);

   // Per-port read mux and hazard detection; x0 is hardwired to zero.
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_port
      logic [REG_IDX_W-1:0] idx;
      logic                 nz;
      logic                 hit;
      assign idx = i_rd_idx[k*REG_IDX_W +: REG_IDX_W];
      assign nz  = (idx != '0);
`ifdef RF_BYPASS_EN
      assign hit = nz && wb_act && (i_wb_dest_reg == idx);
`else
      assign hit = 1'b0;
`endif
      assign port_haz[k] = nz && pending[idx] && !hit;
      assign rd_val[k*WORD_W +: WORD_W] = !nz ? '0 : (hit ? i_wb_dest_data : mem[idx]);
   end

   assign o_hazard = i_valid && (|port_haz);
   assign issue    = i_valid && !stall && !clr && !o_hazard;

   // Scoreboard next state: clr flushes; a newly issued producer beats a same-edge writeback.
   always_comb begin
      pending_nxt = pending;
      if (clr) begin
         pending_nxt = '0;
      end else begin
         if (i_wb_dest_en) pending_nxt[i_wb_dest_reg] = 1'b0;
         if (issue && i_dest_en && (i_dest_reg != '0)) pending_nxt[i_dest_reg] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rf_aresetn) begin
      if (!rf_aresetn) pending <= '0;
      else             pending <= pending_nxt;
   end

   // Register array; writeback ignores stall and clr, writes to x0 are dropped.
   always_ff @(posedge clk or negedge rf_aresetn) begin
      if (!rf_aresetn) begin
         for (int r = 0; r < REG_CNT; r++) mem[r] <= '0;
      end else if (wb_act) begin
         mem[i_wb_dest_reg] <= i_wb_dest_data;
      end
   end

   // Output stage: flush on clr, hold on stall, otherwise capture issue or bubble.
   always_ff @(posedge clk or negedge rf_aresetn) begin
      if (!rf_aresetn) begin
         o_valid   <= 1'b0;
         o_rd_data <= '0;
      end else if (clr) begin
         o_valid   <= 1'b0;
         o_rd_data <= '0;
      end else if (!stall) begin
         o_valid   <= issue;
         o_rd_data <= issue ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed and short random bench for id_regfile_sb (default parameters) with a
// scoreboard of expected read data and a behavioural reference model.
module tb_id_regfile_sb;
   logic        clk = 1'b0;
   logic        rf_aresetn = 1'b1;
   logic        clr = 1'b0, stall = 1'b0, i_valid = 1'b0;
   logic [4:0]  rd0 = '0, rd1 = '0;
   logic        i_dest_en = 1'b0;
   logic [4:0]  i_dest_reg = '0;
   logic        i_wb_dest_en = 1'b0;
   logic [4:0]  i_wb_dest_reg = '0;
   logic [31:0] i_wb_dest_data = '0;
   logic [63:0] o_rd_data;
   logic        o_valid, o_hazard;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_mem [32];
   logic        m_pend [32];
   logic        m_ov;
   logic [63:0] m_od;
   logic [63:0] sbq [$];

   id_regfile_sb dut (
      .clk(clk), .rf_aresetn(rf_aresetn), .clr(clr), .stall(stall),
      .i_valid(i_valid), .i_rd_idx({rd1, rd0}), .i_dest_en(i_dest_en),
      .i_dest_reg(i_dest_reg), .i_wb_dest_en(i_wb_dest_en),
      .i_wb_dest_reg(i_wb_dest_reg), .i_wb_dest_data(i_wb_dest_data),
      .o_rd_data(o_rd_data), .o_valid(o_valid), .o_hazard(o_hazard));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_mem[r]  = '0;
         m_pend[r] = 1'b0;
      end
      m_ov = 1'b0;
      m_od = '0;
      sbq.delete();
   endtask

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
      if (i_wb_dest_en && i_wb_dest_reg == idx) return i_wb_dest_data;
`endif
      return m_mem[idx];
   endfunction

   function automatic logic mhaz(input logic [4:0] idx);
      logic hit;
      hit = 1'b0;
`ifdef RF_BYPASS_EN
      hit = i_wb_dest_en && (i_wb_dest_reg == idx);
`endif
      return (idx != 5'd0) && m_pend[idx] && !hit;
   endfunction

   task automatic drv(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                      input logic de, input logic [4:0] dr,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic st, input logic cl);
      i_valid = v; rd0 = r0; rd1 = r1; i_dest_en = de; i_dest_reg = dr;
      i_wb_dest_en = we; i_wb_dest_reg = wr; i_wb_dest_data = wd;
      stall = st; clr = cl;
   endtask

   // One clock: check hazard before the edge, outputs after it, then advance the model.
   task automatic cycle(input string tag);
      logic eh, iss;
      #2;
      eh = i_valid && (mhaz(rd0) || mhaz(rd1));
      chk({tag, "_hazard"}, 64'(o_hazard), 64'(eh));
      iss = i_valid && !stall && !clr && !eh;
      if (iss) sbq.push_back({mread(rd1), mread(rd0)});
      @(posedge clk);
      #1;
      if (clr) begin
         m_ov = 1'b0; m_od = '0;
      end else if (!stall) begin
         m_ov = iss;
         m_od = '0;
         if (iss && o_valid === 1'b1 && sbq.size() > 0) m_od = sbq.pop_front();
         else if (iss && sbq.size() > 0) begin
            m_od = sbq.pop_front();
         end
      end
      chk({tag, "_valid"}, 64'(o_valid), 64'(m_ov));
      chk({tag, "_data"}, o_rd_data, m_od);
      if (i_wb_dest_en && i_wb_dest_reg != 5'd0) m_mem[i_wb_dest_reg] = i_wb_dest_data;
      if (clr) begin
         for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      end else begin
         if (i_wb_dest_en) m_pend[i_wb_dest_reg] = 1'b0;
         if (iss && i_dest_en && i_dest_reg != 5'd0) m_pend[i_dest_reg] = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      #1 rf_aresetn = 1'b0;
      #2;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_data", o_rd_data, 64'd0);
      chk("rst_hazard", 64'(o_hazard), 64'd0);
      #9 rf_aresetn = 1'b1;
      @(posedge clk); #1;

      // Writeback then read ports (1,0).
      drv(0, 0, 0, 0, 0, 1, 5'd1, 32'hFFFF_FFFF, 0, 0); cycle("wb_x1");
      drv(1, 5'd1, 5'd0, 0, 0, 0, 0, 0, 0, 0);           cycle("rd_x1");
      chk("x1_port0_port1", o_rd_data, {32'd0, 32'hFFFF_FFFF});
      chk("x1_valid", 64'(o_valid), 64'd1);

      // RAW hazard on x5.
      drv(1, 0, 0, 1, 5'd5, 0, 0, 0, 0, 0);              cycle("iss_x5");
      drv(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);              cycle("haz_x5");
      chk("x5_bubble", 64'(o_valid), 64'd0);
      drv(1, 5'd5, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0);    cycle("wb_x5");
`ifndef RF_BYPASS_EN
      chk("x5_nobyp_bubble", 64'(o_valid), 64'd0);
      drv(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);              cycle("rd_x5");
`endif
      chk("x5_data", o_rd_data, 64'h1234);
      chk("x5_valid", 64'(o_valid), 64'd1);

      // Stall holds output; writeback during stall clears pending x3.
      drv(1, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);              cycle("iss_x3");
      drv(1, 5'd1, 5'd1, 0, 0, 0, 0, 0, 0, 0);           cycle("dup_x1");
      chk("dup_ports", o_rd_data, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
      drv(1, 5'd3, 0, 1, 5'd8, 1, 5'd3, 32'h55, 1, 0);   cycle("stall1");
      drv(1, 5'd3, 0, 1, 5'd8, 0, 0, 0, 1, 0);           cycle("stall2");
      cycle("stall3");
      chk("stall_hold_data", o_rd_data, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
      chk("stall_hold_valid", 64'(o_valid), 64'd1);
      drv(1, 5'd3, 5'd8, 0, 0, 0, 0, 0, 0, 0);           cycle("rd_x3");
      chk("x3_after_stall", o_rd_data, 64'h55);

      // clr beats stall and flushes pending x7.
      drv(1, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0);              cycle("iss_x7");
      drv(1, 5'd7, 0, 0, 0, 0, 0, 0, 1, 1);              cycle("clr");
      chk("clr_valid", 64'(o_valid), 64'd0);
      chk("clr_data", o_rd_data, 64'd0);
      drv(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);              cycle("rd_x7");
      chk("x7_issue_after_clr", 64'(o_valid), 64'd1);

      // Same-edge set and clear of x9: set wins.
      drv(1, 0, 0, 1, 5'd9, 1, 5'd9, 32'hA, 0, 0);       cycle("setclr_x9");
      drv(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);              cycle("haz_x9");
      chk("x9_still_pending", 64'(o_valid), 64'd0);
      drv(0, 0, 0, 0, 0, 1, 5'd9, 32'hB, 0, 0);          cycle("wb_x9");
      drv(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);              cycle("rd_x9");
      chk("x9_data", o_rd_data, 64'hB);

      // Short random run against the model.
      for (int i = 0; i < 40; i++) begin
         drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), $urandom,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
         cycle("rand");
      end

      // Asynchronous reset mid-cycle with output valid and pending bits set.
      drv(1, 0, 0, 1, 5'd12, 0, 0, 0, 0, 0);             cycle("iss_x12");
      drv(1, 5'd12, 5'd1, 0, 0, 0, 0, 0, 0, 0);
      #2 rf_aresetn = 1'b0;
      #1;
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_data", o_rd_data, 64'd0);
      chk("arst_hazard", 64'(o_hazard), 64'd0);
      model_reset();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rf_aresetn = 1'b1;
      @(posedge clk); #1;
      drv(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0);       cycle("wb_x0");
      drv(1, 5'd0, 5'd1, 0, 0, 0, 0, 0, 0, 0);           cycle("rd_x0");
      chk("x0_and_x1_zero", o_rd_data, 64'd0);
      chk("x0_valid", 64'(o_valid), 64'd1);
      chk("sbq_empty", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
